serializer8: RTL and testbench
==============================

// Module: serializer8
// PURPOSE
// - Parallel-in/serial-out transmitter. Unloads a WIDTH-bit word, as held by an 8-bit
//   register bank, onto a 1-bit stream with a valid/ready handshake on both sides.
// - Far-end counterpart of the parallel register stage: a remote deserializer rebuilds
//   the word into a register of the same width.
// - Built from plain flip-flops. No primitives beyond D flip-flops and LUT logic.
// PARAMETERS
// - WIDTH      8   Word width in bits. Legal range 2..32.
// - LSB_FIRST  1   1: bit 0 is sent first. 0: bit WIDTH-1 is sent first.
// PORTS
// - CLK        in   1      Single clock. All state changes on the rising edge.
// - RESET      in   1      Synchronous, active-high reset.
// - I          in   WIDTH  Parallel word to send.
// - I_VALID    in   1      I holds a word to load.
// - I_READY    out  1      Serializer will accept I on this edge.
// - SO         out  1      Serial data bit.
// - SO_VALID   out  1      SO carries a valid bit.
// - SO_LAST    out  1      SO is the final bit of the word.
// - SO_READY   in   1      Downstream accepts SO on this edge.
// - BUSY       out  1      A word is in flight (state SHIFT).
// BEHAVIOUR
// - Registered state:
//   - state (IDLE/SHIFT)
//   - shift reg sr[WIDTH-1:0]
//   - bit counter cnt[$clog2(WIDTH)-1:0]
// - Reset (RESET=1 at an edge): state=IDLE, sr=0, cnt=0.
//   - Resulting outputs: SO=0, SO_VALID=0, SO_LAST=0, BUSY=0.
//   - I_READY is forced to 0 while RESET=1.
//   - Reset mid-word aborts the word. Remaining bits are discarded, nothing is replayed.
// - Combinational outputs:
//   - SO = sr[0] (LSB_FIRST=1) or sr[WIDTH-1] (LSB_FIRST=0).
//   - SO_VALID = BUSY = (state==SHIFT).
//   - SO_LAST = SO_VALID && cnt==WIDTH-1.
//   - I_READY = !RESET && (state==IDLE || (SO_LAST && SO_READY)).
//   - I_READY has a combinational path from SO_READY.
// - Input transfer: I_VALID && I_READY at an edge loads sr<=I, cnt<=0, state<=SHIFT.
// - Output transfer: SO_VALID && SO_READY at an edge accepts one bit.
//   - Not last: shift sr one place toward the output end, zero-filling, and cnt<=cnt+1.
//   - Last, with I_VALID=1 in the same cycle: reload (back-to-back). No idle gap.
//   - Last, with I_VALID=0: state<=IDLE, cnt<=0.
// - Latency and throughput:
//   - A word accepted at edge N puts its first bit on SO in cycle N+1.
//   - Last bit appears WIDTH-1 accepted transfers later.
//   - Sustained rate is one bit per cycle with SO_READY=1 and I_VALID=1 continuously.
// - Stall: SO_READY=0 holds SO, SO_LAST, sr and cnt unchanged for any number of cycles.
// - SO and SO_VALID must not change while stalled.
// - I is sampled only on the load edge. I may change freely afterwards.
// - I_VALID=1 while in SHIFT and not on the last bit: no transfer. Source must hold.
// - cnt never exceeds WIDTH-1. There is no wrap within a word.
// TESTING
// - Reset, then load I=8'hA5 with SO_READY=1.
//   -> SO sequence 1,0,1,0,0,1,0,1 in cycles 1..8.
//   -> SO_LAST only in cycle 8. BUSY drops in cycle 9.
// - LSB_FIRST=0, I=8'h81.
//   -> SO sequence 1,0,0,0,0,0,0,1.
//   -> I_READY=0 in cycles 1..7, I_READY=1 in cycle 8.
// - Back-to-back: I=8'hFF then 8'h00, I_VALID held high, SO_READY=1.
//   -> 16 consecutive SO_VALID cycles: 8 ones then 8 zeros.
//   -> Second load on the edge ending cycle 8.
// - Stall: I=8'h3C, SO_READY=0 for 5 cycles after bit 2.
//   -> SO held at bit 2 value (1), cnt frozen.
//   -> Remaining bits intact. Total 8 accepted transfers.
// - Reset mid-word: assert RESET after 3 bits of 8'hC3.
//   -> Next cycle SO_VALID=0, SO=0, I_READY=0 while RESET=1.
//   -> New word 8'h01 after release sends 1,0,0,0,0,0,0,0.
// - I changes to 8'h00 one cycle after loading 8'hF0.
//   -> Transmitted bits still 0,0,0,0,1,1,1,1.

Source files
------------

// File: rtl/serializer8.sv
// serializer8: parallel-in/serial-out transmitter with valid/ready on both sides.
// Ports: CLK, RESET (sync, active-high), I/I_VALID/I_READY (word in),
//        SO/SO_VALID/SO_LAST/SO_READY (bit stream out), BUSY (word in flight).
module serializer8 #(
   parameter int WIDTH     = 8,
   parameter bit LSB_FIRST = 1'b1
) (
   input  logic             CLK,
   input  logic             RESET,
   input  logic [WIDTH-1:0] I,
   input  logic             I_VALID,
   output logic             I_READY,
   output logic             SO,
   output logic             SO_VALID,
   output logic             SO_LAST,
   input  logic             SO_READY,
   output logic             BUSY
);

   localparam int CW = $clog2(WIDTH);

   localparam logic S_IDLE  = 1'b0;
   localparam logic S_SHIFT = 1'b1;

   localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

   logic             state;
   logic [WIDTH-1:0] sr;
   logic [CW-1:0]    cnt;
   logic             shifting;
   logic             load;
   logic             take;
   logic [WIDTH-1:0] sr_next;

   assign shifting = (state == S_SHIFT);
   assign BUSY     = shifting;
   assign SO_VALID = shifting;
   assign SO_LAST  = shifting && (cnt == CNT_LAST);
   assign SO       = LSB_FIRST ? sr[0] : sr[WIDTH-1];

   // Ready combinationally follows SO_READY on the last bit, so a new
   // word can replace the finishing one with no idle cycle.
   assign I_READY = !RESET && (!shifting || (SO_LAST && SO_READY));

   assign load = I_VALID && I_READY;
   assign take = shifting && SO_READY;

   // Move the register one place toward the output end, zero-filling.
   assign sr_next = LSB_FIRST ? {1'b0, sr[WIDTH-1:1]}
                              : {sr[WIDTH-2:0], 1'b0};

   always_ff @(posedge CLK) begin
      if (RESET) begin
         state <= S_IDLE;
         sr    <= '0;
         cnt   <= '0;
      end else if (load) begin
         state <= S_SHIFT;
         sr    <= I;
         cnt   <= '0;
      end else if (take) begin
         if (SO_LAST) begin
            // Clearing sr keeps SO low while idle.
            state <= S_IDLE;
            sr    <= '0;
            cnt   <= '0;
         end else begin
            sr    <= sr_next;
            cnt   <= cnt + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_serializer8.sv
// tb_serializer8: directed bench for serializer8 (LSB-first and MSB-first
// instances) against a queue-based model of the bit stream.
module tb_serializer8;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] din  [2];
   logic       ivl  [2];
   logic       ordy [2];
   logic       irdy [2];
   logic       so   [2];
   logic       sov  [2];
   logic       sol  [2];
   logic       busy [2];

   int total = 0;
   int bad   = 0;
   bit armed = 1'b0;
   bit acc;

   bit mq  [2][$];
   bit cap [2][$];

   int lit_a5 [8] = '{1, 0, 1, 0, 0, 1, 0, 1};
   int lit_81 [8] = '{1, 0, 0, 0, 0, 0, 0, 1};
   int lit_3c [8] = '{0, 0, 1, 1, 1, 1, 0, 0};
   int lit_01 [8] = '{1, 0, 0, 0, 0, 0, 0, 0};
   int lit_f0 [8] = '{0, 0, 0, 0, 1, 1, 1, 1};

   always #5 clk = ~clk;

   serializer8 #(.WIDTH(8), .LSB_FIRST(1'b1)) u_lsb (
      .CLK(clk), .RESET(rst), .I(din[0]), .I_VALID(ivl[0]),
      .I_READY(irdy[0]), .SO(so[0]), .SO_VALID(sov[0]),
      .SO_LAST(sol[0]), .SO_READY(ordy[0]), .BUSY(busy[0])
   );

   serializer8 #(.WIDTH(8), .LSB_FIRST(1'b0)) u_msb (
      .CLK(clk), .RESET(rst), .I(din[1]), .I_VALID(ivl[1]),
      .I_READY(irdy[1]), .SO(so[1]), .SO_VALID(sov[1]),
      .SO_LAST(sol[1]), .SO_READY(ordy[1]), .BUSY(busy[1])
   );

   task automatic chk(string nm, int act, int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d want %0d", nm, act, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   function automatic bit mrdy(int k);
      return !rst && (mq[k].size() == 0 ||
                      (mq[k].size() == 1 && ordy[k]));
   endfunction

   // Compare outputs against the model, log accepted bits, then advance
   // the model across the coming edge (inputs are stable by now).
   always @(negedge clk) begin
      for (int k = 0; k < 2; k++) begin
         bit r;
         if (armed) begin
            chk($sformatf("valid[%0d]", k), int'(sov[k]),
                int'(mq[k].size() > 0));
            chk($sformatf("busy[%0d]", k), int'(busy[k]),
                int'(mq[k].size() > 0));
            chk($sformatf("last[%0d]", k), int'(sol[k]),
                int'(mq[k].size() == 1));
            chk($sformatf("irdy[%0d]", k), int'(irdy[k]),
                int'(mrdy(k)));
            if (mq[k].size() > 0)
               chk($sformatf("so[%0d]", k), int'(so[k]),
                   int'(mq[k][0]));
         end
         if (sov[k] === 1'b1 && ordy[k] && !rst)
            cap[k].push_back(so[k]);
         r = mrdy(k);
         if (rst) begin
            mq[k].delete();
         end else begin
            if (mq[k].size() > 0 && ordy[k])
               void'(mq[k].pop_front());
            if (ivl[k] && r)
               for (int b = 0; b < 8; b++)
                  mq[k].push_back(k == 0 ? din[k][b] : din[k][7-b]);
         end
      end
   end

   initial begin
      rst = 1'b1;
      for (int k = 0; k < 2; k++) begin
         din[k]  = 8'h00;
         ivl[k]  = 1'b0;
         ordy[k] = 1'b1;
      end
      cyc();
      armed = 1'b1;
      cyc();
      settle();
      chk("rst_so", int'(so[0]), 0);
      chk("rst_valid", int'(sov[0]), 0);
      chk("rst_last", int'(sol[0]), 0);
      chk("rst_busy", int'(busy[0]), 0);
      chk("rst_irdy", int'(irdy[0]), 0);
      rst = 1'b0;
      cyc();

      din[0] = 8'hA5;
      ivl[0] = 1'b1;
      settle();
      chk("a5_irdy_idle", int'(irdy[0]), 1);
      cyc();
      ivl[0] = 1'b0;
      for (int k = 1; k <= 8; k++) begin
         settle();
         chk($sformatf("a5_bit%0d", k), int'(so[0]), lit_a5[k-1]);
         chk($sformatf("a5_last%0d", k), int'(sol[0]), int'(k == 8));
         cyc();
      end
      settle();
      chk("a5_busy_c9", int'(busy[0]), 0);
      cyc();

      din[1] = 8'h81;
      ivl[1] = 1'b1;
      cyc();
      ivl[1] = 1'b0;
      for (int k = 1; k <= 8; k++) begin
         settle();
         chk($sformatf("81_bit%0d", k), int'(so[1]), lit_81[k-1]);
         chk($sformatf("81_irdy%0d", k), int'(irdy[1]), int'(k == 8));
         cyc();
      end
      cyc();

      din[0] = 8'hFF;
      ivl[0] = 1'b1;
      cyc();
      din[0] = 8'h00;
      for (int k = 1; k <= 16; k++) begin
         if (k == 9) ivl[0] = 1'b0;
         settle();
         chk($sformatf("b2b_valid%0d", k), int'(sov[0]), 1);
         chk($sformatf("b2b_so%0d", k), int'(so[0]), int'(k <= 8));
         if (k == 8) chk("b2b_irdy8", int'(irdy[0]), 1);
         cyc();
      end
      settle();
      chk("b2b_busy_end", int'(busy[0]), 0);
      cyc();

      cap[0].delete();
      din[0] = 8'h3C;
      ivl[0] = 1'b1;
      cyc();
      ivl[0] = 1'b0;
      din[0] = 8'hFF;
      for (int k = 1; k <= 15; k++) begin
         ordy[0] = !(k >= 3 && k <= 7);
         settle();
         if (k >= 3 && k <= 7) begin
            chk($sformatf("stall_so%0d", k), int'(so[0]), 1);
            chk($sformatf("stall_last%0d", k), int'(sol[0]), 0);
         end
         cyc();
      end
      ordy[0] = 1'b1;
      chk("stall_count", cap[0].size(), 8);
      for (int b = 0; b < 8 && b < cap[0].size(); b++)
         chk($sformatf("stall_cap%0d", b), int'(cap[0][b]), lit_3c[b]);

      din[0] = 8'hC3;
      ivl[0] = 1'b1;
      cyc();
      ivl[0] = 1'b0;
      repeat (3) cyc();
      rst = 1'b1;
      settle();
      chk("mid_irdy_c4", int'(irdy[0]), 0);
      cyc();
      settle();
      chk("mid_valid", int'(sov[0]), 0);
      chk("mid_so", int'(so[0]), 0);
      chk("mid_irdy", int'(irdy[0]), 0);
      rst = 1'b0;
      cyc();
      cap[0].delete();
      din[0] = 8'h01;
      ivl[0] = 1'b1;
      cyc();
      ivl[0] = 1'b0;
      repeat (9) cyc();
      chk("w01_count", cap[0].size(), 8);
      for (int b = 0; b < 8 && b < cap[0].size(); b++)
         chk($sformatf("w01_cap%0d", b), int'(cap[0][b]), lit_01[b]);

      cap[0].delete();
      din[0] = 8'hF0;
      ivl[0] = 1'b1;
      cyc();
      din[0] = 8'h00;
      ivl[0] = 1'b0;
      repeat (9) cyc();
      chk("f0_count", cap[0].size(), 8);
      for (int b = 0; b < 8 && b < cap[0].size(); b++)
         chk($sformatf("f0_cap%0d", b), int'(cap[0][b]), lit_f0[b]);

      // Mixed traffic on the MSB-first unit; source holds until taken.
      for (int n = 0; n < 120; n++) begin
         ordy[1] = ($urandom_range(0, 3) != 0);
         if (!ivl[1]) begin
            ivl[1] = 1'($urandom_range(0, 1));
            din[1] = 8'($urandom);
         end
         settle();
         acc = ivl[1] && irdy[1];
         cyc();
         if (acc) ivl[1] = 1'b0;
      end
      ivl[1]  = 1'b0;
      ordy[1] = 1'b1;
      repeat (12) cyc();
      chk("mix_idle", int'(busy[1]), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
